seg7_capture: RTL and testbench
===============================

# seg7_capture

Readback and checker for the board's six seven-segment displays. It watches the active-low HEX buses driven by the display encoder, waits until they hold steady, and decodes the glyphs back into a 24-bit hex value. It then compares that value against an expected word and reports the result over a valid/ready handshake. It sits beside the top-level display path for on-chip self-check and bench scoring of computed results.

## Interface
- NUM_DIGITS, 6, number of displays captured; value width is NUM_DIGITS*4.
- STABLE_CYCLES, 4, consecutive identical samples required before a capture is accepted; minimum 1.
- TIMEOUT_CYCLES, 1024, maximum time spent settling before a forced capture; must be greater than STABLE_CYCLES.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle arm request; honoured only in IDLE.
- hex_in  in  NUM_DIGITS*7  segment buses, active-low, digit 0 in [6:0], digit 1 in [13:7], and so on; bit order is g..a, MSB = g.
- expected  in  NUM_DIGITS*4  reference value, sampled on the accepted start edge.
- ready  in  1  consumer accepts the result.
- value_out  out  NUM_DIGITS*4  decoded value; digit k occupies nibble k.
- valid  out  1  result available.
- match  out  1  value_out equals the sampled expected, with no bad glyph and no timeout.
- bad_glyph  out  1  at least one digit held a non-hex pattern.
- timeout  out  1  capture was forced by TIMEOUT_CYCLES.
- busy  out  1  state is not IDLE.

## Operation
- **States:** IDLE, SETTLE, HOLD.
- **Outputs:** all registered. valid, match, bad_glyph and timeout are asserted only in HOLD.
- **IDLE:**
  - On start, go to SETTLE.
  - On the same edge: snapshot <= hex_in, stable_cnt <= 1, elapsed <= 1, exp_reg <= expected.
  - ready is ignored.
- **SETTLE, on every edge:**
  - If hex_in == snapshot, stable_cnt increments (saturating).
  - Otherwise snapshot <= hex_in and stable_cnt <= 1.
  - elapsed increments on every edge.
  - start is ignored.
- **Exit to HOLD:** on the edge where stable_cnt would reach STABLE_CYCLES. If STABLE_CYCLES=1, the start edge itself enters HOLD.
- **Forced exit:** if stability is not reached, HOLD is entered on the edge where elapsed would reach TIMEOUT_CYCLES. timeout=1 and the decoded snapshot is latched.
  - If stability and timeout coincide on the same edge, stability wins and timeout=0.
- **HOLD entry:**
  - value_out, bad_glyph and match are computed from the final snapshot and exp_reg.
  - valid=1.
- **HOLD behaviour:**
  - All outputs are frozen; hex_in and start are ignored.
  - On valid && ready, go to IDLE; valid, match, bad_glyph and timeout drop on that edge.
  - value_out keeps its last value until the next HOLD entry.
- **Decode table (active-low, g..a):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern, including blank 1111111, decodes to 0x0 and sets bad_glyph.
- **Compare:** match = !bad_glyph && !timeout && (value_out == exp_reg), over the full NUM_DIGITS*4 width.

## Timing
- **Reset:** state IDLE; value_out=0, valid=0, match=0, bad_glyph=0, timeout=0, busy=0; all counters and the snapshot cleared.
- **Reset mid-SETTLE or mid-HOLD:** IDLE on the next edge, outputs at reset values, and any pending result is discarded.
- **busy:** rises on the edge after start is sampled and falls on the handshake edge.
- **Latency with constant hex_in:** valid rises STABLE_CYCLES-1 edges after the start edge. With the default of 4, that is 3 cycles.
- **After the last input change:** valid rises STABLE_CYCLES-1 edges after the edge that samples the new pattern.
- **Timeout:** valid rises TIMEOUT_CYCLES-1 edges after the start edge.
- **Back-to-back:** a start asserted in the cycle after the handshake edge is accepted. There is at most one result in flight.
- **Counter widths:** sized to hold STABLE_CYCLES and TIMEOUT_CYCLES respectively; no wrap is permitted.

## Test plan
1. **Matching capture.** hex0..5 = 0000000, 0010010, 0000011, 1111001, 1000000, 1000000 (constant); expected=0x001B58; start pulse -> valid 3 cycles after the start edge, value_out=0x001B58, match=1, bad_glyph=0, timeout=0.
2. **Mismatch.** Same hex_in, expected=0x001B59 -> valid after 3 cycles, value_out=0x001B58, match=0.
3. **Settling after changes.** hex0 alternates 0000000/1111000 every 2 cycles for 20 cycles after start, then holds 1111000 -> no valid during toggling; valid 3 cycles after the final change; value_out nibble 0 = 0x7.
4. **Forced timeout.** TIMEOUT_CYCLES=16; hex0 toggles every cycle indefinitely -> valid 15 cycles after the start edge, timeout=1, match=0.
5. **Illegal glyph.** hex3=0101010, other digits as in scenario 1 -> bad_glyph=1, value_out=0x000B58, match=0.
6. **Backpressure and reset.** Hold ready low 10 cycles in HOLD while changing hex_in -> valid and value_out unchanged; ready high for 1 cycle -> valid=0 and busy=0 next cycle. Then start and assert rst 2 cycles later -> all outputs 0 and busy=0 on the next edge.

Source files
------------

// File: rtl/seg7_capture.sv
// seg7_capture: decodes six active-low seven-segment buses once stable and checks against an expected word
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_start            arm request, honoured only while idle
//   i_hex_in           NUM_DIGITS segment buses, g..a, active-low, digit 0 in [6:0]
//   i_expected         reference word, sampled on the accepted start edge
//   i_ready            consumer accepts the held result
//   o_value_out        decoded value, digit k in nibble k
//   o_valid            result held and available
//   o_match            value equals reference with no bad glyph and no timeout
//   o_bad_glyph        some digit showed a non-hex pattern
//   o_timeout          capture was forced by the settle time limit
//   o_busy             not idle
module seg7_capture #(
    parameter int NUM_DIGITS     = 6,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [NUM_DIGITS*7-1:0] i_hex_in,
    input  logic [NUM_DIGITS*4-1:0] i_expected,
    input  logic                    i_ready,
    output logic [NUM_DIGITS*4-1:0] o_value_out,
    output logic                    o_valid,
    output logic                    o_match,
    output logic                    o_bad_glyph,
    output logic                    o_timeout,
    output logic                    o_busy
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2;
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    logic [1:0]              r_state;
    logic [NUM_DIGITS*7-1:0] r_snap;
    logic [NUM_DIGITS*4-1:0] r_exp;
    logic [SW-1:0]           r_stable;
    logic [TW-1:0]           r_elapsed;
    logic [NUM_DIGITS*4-1:0] w_val;
    logic [NUM_DIGITS-1:0]   w_bad_d;
    logic [SW-1:0]           w_stable_nxt;
    logic [TW-1:0]           w_elapsed_nxt;
    logic                    w_bad, w_stable_hit, w_timeout_hit, w_enter, w_to, w_match;

    // bit 4 flags a pattern outside the hex glyph set
    function automatic logic [4:0] decode7(input logic [6:0] s);
        case (s)
            7'b1000000: return 5'h00;
            7'b1111001: return 5'h01;
            7'b0100100: return 5'h02;
            7'b0110000: return 5'h03;
            7'b0011001: return 5'h04;
            7'b0010010: return 5'h05;
            7'b0000010: return 5'h06;
            7'b1111000: return 5'h07;
            7'b0000000: return 5'h08;
            7'b0010000: return 5'h09;
            7'b0001000: return 5'h0A;
            7'b0000011: return 5'h0B;
            7'b1000110: return 5'h0C;
            7'b0100001: return 5'h0D;
            7'b0000110: return 5'h0E;
            7'b0001110: return 5'h0F;
            default:    return 5'h10;
        endcase
    endfunction

    // The snapshot after any update always equals i_hex_in, so the live bus is decoded
    // directly for the HOLD entry edge.
    always_comb begin
        w_val   = '0;
        w_bad_d = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            {w_bad_d[k], w_val[k*4+:4]} = decode7(i_hex_in[k*7+:7]);
    end

    assign w_bad         = |w_bad_d;
    assign w_stable_nxt  = (i_hex_in == r_snap) ? ((r_stable == STABLE_MAX) ? r_stable : r_stable + SW'(1)) : SW'(1);
    assign w_elapsed_nxt = (r_elapsed == TIMEOUT_MAX) ? r_elapsed : r_elapsed + TW'(1);
    assign w_stable_hit  = w_stable_nxt == STABLE_MAX;
    assign w_timeout_hit = w_elapsed_nxt == TIMEOUT_MAX;
    assign w_match       = !w_bad && (w_val == ((r_state == IDLE) ? i_expected : r_exp));
    // a single-sample stability requirement is met by the start edge itself
    assign w_enter       = (r_state == IDLE && i_start && STABLE_CYCLES == 1) ||
                           (r_state == SETTLE && (w_stable_hit || w_timeout_hit));
    assign w_to          = r_state == SETTLE && !w_stable_hit && w_timeout_hit;
    assign o_busy        = r_state != IDLE;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_snap      <= '0;
            r_exp       <= '0;
            r_stable    <= '0;
            r_elapsed   <= '0;
            o_value_out <= '0;
            o_valid     <= 1'b0;
            o_match     <= 1'b0;
            o_bad_glyph <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            if (r_state == IDLE && i_start) begin
                r_state   <= SETTLE;
                r_snap    <= i_hex_in;
                r_stable  <= SW'(1);
                r_elapsed <= TW'(1);
                r_exp     <= i_expected;
            end
            if (r_state == SETTLE) begin
                r_snap    <= i_hex_in;
                r_stable  <= w_stable_nxt;
                r_elapsed <= w_elapsed_nxt;
            end
            if (w_enter) begin
                r_state     <= HOLD;
                o_value_out <= w_val;
                o_bad_glyph <= w_bad;
                o_match     <= w_match && !w_to;
                o_timeout   <= w_to;
                o_valid     <= 1'b1;
            end
            if (r_state == HOLD && i_ready) begin
                r_state     <= IDLE;
                o_valid     <= 1'b0;
                o_match     <= 1'b0;
                o_bad_glyph <= 1'b0;
                o_timeout   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: scoreboard bench for seg7_capture with a short-timeout second instance
module tb_seg7_capture;
    typedef struct {
        string       n;
        logic [23:0] v;
        logic        m, b, t;
        int          c;
    } exp_t;

    logic        clk = 0, rst = 1, start = 0, start2 = 0, ready = 1;
    logic [41:0] hex, base;
    logic [23:0] expected;
    logic [23:0] val, val2;
    logic        valid, match, bad, to, busy;
    logic        valid2, match2, bad2, to2, busy2;
    int          cyc = 0, checks = 0, errors = 0, s;
    bit          pv = 0, pv2 = 0;
    exp_t        q[$], q2[$];
    exp_t        e1, e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_capture dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_hex_in(hex), .i_expected(expected),
        .i_ready(ready), .o_value_out(val), .o_valid(valid), .o_match(match),
        .o_bad_glyph(bad), .o_timeout(to), .o_busy(busy)
    );

    seg7_capture #(.TIMEOUT_CYCLES(16)) dut_to (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_hex_in(hex), .i_expected(expected),
        .i_ready(1'b1), .o_value_out(val2), .o_valid(valid2), .o_match(match2),
        .o_bad_glyph(bad2), .o_timeout(to2), .o_busy(busy2)
    );

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [23:0] e, input bit second);
        expected = e;
        if (second) start2 = 1; else start = 1;
        tick();
        start = 0;
        start2 = 0;
        s = cyc;
    endtask

    task automatic push(input string n, input logic [23:0] v, input logic m, b, t, input int c);
        exp_t x;
        x.n = n; x.v = v; x.m = m; x.b = b; x.t = t; x.c = c;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (valid && !pv) begin
            if (q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e1 = q.pop_front();
                chk({e1.n, "_value"}, 32'(val), 32'(e1.v));
                chk({e1.n, "_match"}, 32'(match), 32'(e1.m));
                chk({e1.n, "_bad"}, 32'(bad), 32'(e1.b));
                chk({e1.n, "_timeout"}, 32'(to), 32'(e1.t));
                chk({e1.n, "_cycle"}, cyc, e1.c);
            end
        end
        pv = valid;
    end

    always @(negedge clk) begin
        if (valid2 && !pv2) begin
            if (q2.size() == 0) chk("unexpected_valid2", 1, 0);
            else begin
                e2 = q2.pop_front();
                chk({e2.n, "_value"}, 32'(val2), 32'(e2.v));
                chk({e2.n, "_match"}, 32'(match2), 32'(e2.m));
                chk({e2.n, "_bad"}, 32'(bad2), 32'(e2.b));
                chk({e2.n, "_timeout"}, 32'(to2), 32'(e2.t));
                chk({e2.n, "_cycle"}, cyc, e2.c);
            end
        end
        pv2 = valid2;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t x;
        base = {seg(4'h0), seg(4'h0), seg(4'h1), seg(4'hB), seg(4'h5), seg(4'h8)};
        hex = base;
        expected = '0;
        repeat (3) tick();
        chk("rst_value", 32'(val), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_match", 32'(match), 0);
        chk("rst_bad", 32'(bad), 0);
        chk("rst_timeout", 32'(to), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 0;
        tick();

        go(24'h001B58, 0);
        push("s1", 24'h001B58, 1, 0, 0, s + 3);
        chk("s1_busy", 32'(busy), 1);
        repeat (6) tick();

        go(24'h001B59, 0);
        push("s2", 24'h001B58, 0, 0, 0, s + 3);
        repeat (6) tick();

        go(24'h001B57, 0);
        for (int i = 0; i < 10; i++) begin
            hex[6:0] = (i % 2 == 0) ? seg(4'h7) : seg(4'h8);
            repeat (2) tick();
        end
        hex[6:0] = seg(4'h7);
        tick();
        push("s3", 24'h001B57, 1, 0, 0, cyc + 3);
        repeat (6) tick();
        hex = base;

        hex[27:21] = 7'b0101010;
        go(24'h000B58, 0);
        push("s5", 24'h000B58, 0, 1, 0, s + 3);
        repeat (6) tick();
        hex = base;

        go(24'h001B58, 1);
        x.n = "s4"; x.v = 24'h001B57; x.m = 0; x.b = 0; x.t = 1; x.c = s + 15;
        q2.push_back(x);
        for (int i = 0; i < 20; i++) begin
            hex[6:0] = (i % 2 == 0) ? seg(4'h7) : seg(4'h8);
            tick();
        end
        hex = base;
        repeat (4) tick();

        ready = 0;
        go(24'h001B58, 0);
        push("s6", 24'h001B58, 1, 0, 0, s + 3);
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            hex[6:0] = seg(4'(i));
            tick();
            chk("s6_hold_valid", 32'(valid), 1);
            chk("s6_hold_value", 32'(val), 32'h001B58);
            chk("s6_hold_busy", 32'(busy), 1);
        end
        hex = base;
        ready = 1;
        tick();
        ready = 0;
        chk("s6_hs_valid", 32'(valid), 0);
        chk("s6_hs_busy", 32'(busy), 0);
        chk("s6_hs_match", 32'(match), 0);
        go(24'h001B58, 0);
        tick();
        rst = 1;
        tick();
        chk("s6_rst_value", 32'(val), 0);
        chk("s6_rst_valid", 32'(valid), 0);
        chk("s6_rst_match", 32'(match), 0);
        chk("s6_rst_bad", 32'(bad), 0);
        chk("s6_rst_timeout", 32'(to), 0);
        chk("s6_rst_busy", 32'(busy), 0);
        rst = 0;
        ready = 1;
        repeat (8) tick();

        chk("queue_empty", q.size(), 0);
        chk("queue2_empty", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
